// File: rtl/st_c2h_patt_src_if.sv
`default_nettype none
// ============================================================
// st_c2h_patt_src_if : FIFO pop handshake between the pattern source and the C2H stage
// Rev 1.0
// ============================================================
interface st_c2h_patt_src_if #(
  parameter int BIT_WIDTH = 64
);
  logic                   rd;
  logic [BIT_WIDTH-1:0]   dout;
  logic [BIT_WIDTH/8-1:0] dpar;
  logic                   rdout;
  logic                   hfull;

  modport master (input rd, output dout, output dpar, output rdout, output hfull);
  modport slave  (output rd, input dout, input dpar, input rdout, input hfull);
endinterface
`default_nettype wire

// File: rtl/st_c2h_patt_src.sv
`default_nettype none
// ============================================================
// st_c2h_patt_src : incrementing-lane packet generator feeding a beat FIFO
// Rev 1.0
// ============================================================
module st_c2h_patt_src #(
  parameter int BIT_WIDTH  = 64,
  parameter int PATT_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic [31:0]                   control_reg,
  input  logic [15:0]                   txr_size,
  input  logic [10:0]                   num_pkt,
  st_c2h_patt_src_if.master             fifo,
  output logic                          gen_busy,
  output logic                          gen_done,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int LANES = BIT_WIDTH / PATT_WIDTH;
  localparam int BYTES = BIT_WIDTH / 8;
  localparam int LOG2B = $clog2(BYTES);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] HALF_L  = (AW+1)'(FIFO_DEPTH / 2);

  typedef enum logic [0:0] {IDLE = 1'b0, GEN = 1'b1} state_t;

  state_t state, state_nx;
  logic   done_nx;

  logic              ctrl_q, ctrl_qq;
  logic              start;
  logic [13:0]       beats_pp, beat_cnt;
  logic [LOG2B-1:0]  tail;
  logic [10:0]       pkts, pkt_cnt;
  logic [16:0]       bsum;
  logic [13:0]       bpp_w;

  logic [BIT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [AW:0]          level_r;
  logic [BIT_WIDTH-1:0] dout_r, rdata, patt, wdata;
  logic [BYTES-1:0]     dpar_r, rpar, keep;
  logic                 rdout_r, done_r;
  logic                 push, pop, last_beat, last_pkt, fin;
  logic [31:0]          lane_base;
  logic                 unused_ctrl;

  assign unused_ctrl = ^{control_reg[31:2], control_reg[0]};

  // Edge detector flops reset high so a start held across reset is not taken.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      ctrl_q  <= 1'b1;
      ctrl_qq <= 1'b1;
    end else begin
      ctrl_q  <= control_reg[1];
      ctrl_qq <= ctrl_q;
    end
  end

  assign start = ctrl_q & ~ctrl_qq;

  assign bsum  = {1'b0, txr_size} + 17'(BYTES - 1);
  assign bpp_w = (txr_size == 16'd0) ? 14'd1 : 14'(bsum >> LOG2B);

  assign push      = (state == GEN) && (level_r < DEPTH_L);
  assign pop       = fifo.rd && (level_r != '0);
  assign last_beat = (beat_cnt == beats_pp - 14'd1);
  assign last_pkt  = (pkt_cnt == pkts - 11'd1);
  assign fin       = push && last_beat && last_pkt;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state  <= IDLE;
      done_r <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_pkt != 11'd0) state_nx = GEN;
          else                  done_nx  = 1'b1;
        end
      end
      GEN: begin
        if (fin) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      beats_pp <= '0;
      tail     <= '0;
      pkts     <= '0;
      beat_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (state == IDLE && start) begin
      beats_pp <= bpp_w;
      tail     <= txr_size[LOG2B-1:0];
      pkts     <= num_pkt;
      beat_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (push) begin
      if (last_beat) begin
        beat_cnt <= '0;
        pkt_cnt  <= pkt_cnt + 11'd1;
      end else begin
        beat_cnt <= beat_cnt + 14'd1;
      end
    end
  end

  assign lane_base = 32'(beat_cnt) * 32'(LANES);
  assign rdata     = mem[rptr];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign patt[i*PATT_WIDTH +: PATT_WIDTH] = PATT_WIDTH'(lane_base + 32'(i));
  end

  // Bytes past the packet length in the final beat are zeroed.
  for (genvar j = 0; j < BYTES; j++) begin : g_byte
    assign keep[j]           = !(last_beat && (tail != '0) && (LOG2B'(j) >= tail));
    assign wdata[j*8 +: 8]   = keep[j] ? patt[j*8 +: 8] : 8'h00;
    assign rpar[j]           = ^rdata[j*8 +: 8];
  end

  always_ff @(posedge axi_aclk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wptr    <= '0;
      rptr    <= '0;
      level_r <= '0;
      dout_r  <= '0;
      dpar_r  <= '0;
      rdout_r <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr   <= rptr + 1'b1;
        dout_r <= rdata;
        dpar_r <= rpar;
      end
      rdout_r <= pop;
      case ({push, pop})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  assign fifo.dout  = dout_r;
  assign fifo.dpar  = dpar_r;
  assign fifo.rdout = rdout_r;
  assign fifo.hfull = (level_r >= HALF_L);
  assign gen_busy   = (state == GEN);
  assign gen_done   = done_r;
  assign level      = level_r;

endmodule
`default_nettype wire

// File: doc/st_c2h_patt_src.md
# st_c2h_patt_src

Upstream data source for the C2H streaming generator. On a start command it produces `num_pkt` packets of `txr_size` bytes each as an incrementing `PATT_WIDTH`-bit lane pattern and writes them into an internal beat FIFO. The C2H stage drains that FIFO through the `rd` / `dout` / `rdout` / `hfull` handshake and forwards the beats unchanged as `c2h_tdata`, with `dpar` as `c2h_dpar`.

## Interface
Parameters:
- `BIT_WIDTH`, 64 — beat width in bits; one of 64, 128, 256, 512.
- `PATT_WIDTH`, 16 — pattern lane width in bits; 16 or 32. Lanes per beat: `LANES = BIT_WIDTH/PATT_WIDTH`.
- `FIFO_DEPTH`, 16 — FIFO depth in beats; a power of two, at least 4.

Ports:
- `axi_aclk` in 1 — single clock.
- `axi_areset` in 1 — reset, synchronous, active-high.
- `control_reg` in 32 — bit 1 is the start command. Other bits are ignored.
- `txr_size` in 16 — packet length in bytes. Sampled at start.
- `num_pkt` in 11 — number of packets. Sampled at start.
- `rd` in 1 — FIFO pop request from the C2H stage.
- `dout` out `BIT_WIDTH` — popped beat.
- `dpar` out `BIT_WIDTH/8` — even parity per byte of `dout`. Bit j is the XOR of `dout[8j+7:8j]`.
- `rdout` out 1 — `dout`/`dpar` valid for this cycle.
- `hfull` out 1 — FIFO level ≥ `FIFO_DEPTH/2`.
- `gen_busy` out 1 — generator state is `GEN`.
- `gen_done` out 1 — one-cycle pulse after the last beat is written.
- `level` out `$clog2(FIFO_DEPTH)+1` — current FIFO occupancy.

## Operation
- Start detection:
  - `control_reg[1]` is registered once.
  - A start is a 0→1 edge of the registered copy.
  - Starts are ignored unless the state is `IDLE`.
- On start, latch:
  - `beats_pp = ceil(txr_size/(BIT_WIDTH/8))`; `txr_size = 0` gives 1 beat.
  - `tail = txr_size % (BIT_WIDTH/8)`.
  - `pkts = num_pkt`.
- States:
  - `IDLE`: on start with `num_pkt ≠ 0` → `GEN`. On start with `num_pkt = 0` → stay in `IDLE` and pulse `gen_done`.
  - `GEN`: write one beat per cycle whenever `level < FIFO_DEPTH`. After the beat with `pkt_cnt = pkts-1` and `beat_cnt = beats_pp-1` is written → `IDLE`, and `gen_done` pulses the following cycle.
- Counters (both reset to 0 at start):
  - `beat_cnt`, 14 bits: wraps to 0 at the end of each packet.
  - `pkt_cnt`, 11 bits: increments at each packet end.
- Beat content:
  - Lane i (bits `[i*PATT_WIDTH +: PATT_WIDTH]`) = `(beat_cnt*LANES + i) mod 2^PATT_WIDTH`.
  - The pattern restarts at 0 for every packet.
  - In the last beat of a packet with `tail ≠ 0`, bytes at index ≥ `tail` are forced to 0.
- FIFO:
  - Circular buffer with a write pointer and a read pointer, each wrapping mod `FIFO_DEPTH`.
  - Write is gated by `level < FIFO_DEPTH`, evaluated on the registered level. There is no write-through when full, even if `rd` is active in the same cycle.
  - A pop happens when `rd & (level ≠ 0)`. `rd` while empty is ignored: no pointer move, `rdout = 0`.
  - Simultaneous push and pop leave `level` unchanged.
- `control_reg`, `txr_size` and `num_pkt` changes during `GEN` have no effect.

## Timing
- Start: registered edge at cycle S; `gen_busy = 1` at S+1; first FIFO write takes effect at S+1; `level = 1` at S+2.
- Read latency is 1 cycle:
  - `rd` high at cycle N with a non-empty FIFO → `dout`/`dpar` hold that entry and `rdout = 1` at N+1.
  - `dout` holds its value while `rdout = 0`.
- `hfull`, `level` and `gen_busy` are decoded from registered state; there is no combinational path from `rd`.
- Throughput: 1 beat/cycle written and 1 beat/cycle read, sustained.
- Reset values: `dout = 0`, `dpar = 0`, `rdout = 0`, `hfull = 0`, `gen_busy = 0`, `gen_done = 0`, `level = 0`. Pointers and counters are 0 and the state is `IDLE`.
- Reset mid-operation:
  - The FIFO contents are discarded and the generation is abandoned.
  - No `gen_done` pulse is produced.
  - A new start requires a fresh 0→1 edge on `control_reg[1]` after reset is released.

## Test plan
- **Basic packet.** `BIT_WIDTH=64`, `PATT_WIDTH=16`, `txr_size=16`, `num_pkt=1`, `rd` held high → exactly 2 beats on `dout`:
  - beat 0 = `0x0003_0002_0001_0000`, beat 1 = `0x0007_0006_0005_0004`;
  - `dpar` matches per-byte XOR;
  - `gen_done` pulses once.
- **Tail masking.** `txr_size=10` → 2 beats; beat 1 = `0x0000_0000_0000_0004` (bytes 2–7 zeroed, only lane 0 kept).
- **Backpressure, full FIFO.** `rd` held low, `txr_size=256`, `FIFO_DEPTH=16`:
  - `level` stops at 16;
  - `hfull` rises when `level` reaches 8;
  - then `rd` high: all 32 beats arrive in order with none lost or duplicated.
- **Edge cases.**
  - `txr_size=0`, `num_pkt=3` → 3 single-beat packets, each all-lanes pattern starting at 0.
  - `num_pkt=0` → `gen_done` pulse with no writes.
- **Simultaneous push/pop and empty read.**
  - With `level=16`, assert `rd` for 1 cycle → no write that cycle; `level=15` next cycle.
  - `rd` pulsed while empty → `rdout` stays 0.
- **Reset mid-generation.** Assert `axi_areset` after 5 beats are written → all outputs return to their reset values; a restart after reset regenerates the pattern from lane value 0.
